// File: rtl/leb128_collect.sv
// ============================================================================
// Module   : leb128_collect
// Brief    : Gathers one LEB128 varint (<= MAXB bytes) into a 5-byte window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module leb128_collect #(
    parameter int MAXB = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] o0,
    output logic [7:0] o1,
    output logic [7:0] o2,
    output logic [7:0] o3,
    output logic [7:0] o4,
    output logic [2:0] out_len,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [2:0] C_LAST    = 3'(MAXB - 1);
    localparam logic [2:0] C_LEN_MAX = 3'(MAXB);

    state_t     state_q, state_d;
    logic [7:0] slot_q [MAXB];
    logic [7:0] slot_d [MAXB];
    logic [2:0] idx_q, idx_d;
    logic [2:0] len_q, len_d;
    logic       err_q, err_d;
    logic [2:0] w_base;
    logic [39:0] w_win;

    assign in_ready  = (state_q == COLLECT) || out_ready;
    assign out_valid = (state_q == HOLD);
    assign out_len   = len_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        w_base  = idx_q;

        // Consuming the window frees every slot so the next varint starts clean.
        if (state_q == HOLD && out_ready) begin
            for (int i = 0; i < MAXB; i++) begin
                slot_d[i] = 8'h00;
            end
            idx_d   = 3'd0;
            len_d   = 3'd0;
            err_d   = 1'b0;
            state_d = COLLECT;
            w_base  = 3'd0;
        end

        if (in_valid && in_ready) begin
            slot_d[w_base] = in_data;
            idx_d          = w_base + 3'd1;
            if (!in_data[7]) begin
                state_d = HOLD;
                len_d   = w_base + 3'd1;
                err_d   = 1'b0;
            end else if (w_base == C_LAST) begin
                state_d = HOLD;
                len_d   = C_LEN_MAX;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            for (int i = 0; i < MAXB; i++) begin
                slot_q[i] <= 8'h00;
            end
            idx_q <= 3'd0;
            len_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        w_win = '0;
        for (int i = 0; i < MAXB && i < 5; i++) begin
            w_win[i*8 +: 8] = slot_q[i];
        end
    end

    assign o0 = w_win[7:0];
    assign o1 = w_win[15:8];
    assign o2 = w_win[23:16];
    assign o3 = w_win[31:24];
    assign o4 = w_win[39:32];

endmodule

`default_nettype wire

// File: tb/tb_leb128_collect.sv
// ============================================================================
// Module   : tb_leb128_collect
// Brief    : Scoreboard bench for leb128_collect with a byte-stream framing model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_leb128_collect;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o0, o1, o2, o3, o4;
    logic [2:0] out_len;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    leb128_collect #(.MAXB(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o4        (o4),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] win;
        logic [2:0]  len;
        logic        err;
    } exp_t;

    exp_t       sbq [$];
    logic [7:0] cur [$];
    int         checks = 0;
    int         errors = 0;
    int         rmode  = 0;   // 0 random out_ready, 1 forced high, 2 manual

    function automatic logic [39:0] win_now();
        return {o4, o3, o2, o1, o0};
    endfunction

    // out_ready pattern generator for the random phase
    always @(posedge clk) begin
        #1;
        if (rmode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else if (rmode == 1) out_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on each output handshake, checks handshake rules
    logic        prev_hold = 1'b0;
    logic [39:0] prev_win;
    logic [2:0]  prev_len;
    logic        prev_err;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output win=%h len=%0d err=%0d (scoreboard empty)",
                             win_now(), out_len, out_err);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (win_now() !== e.win || out_len !== e.len || out_err !== e.err) begin
                        errors++;
                        $display("FAIL window got win=%h len=%0d err=%0d want win=%h len=%0d err=%0d",
                                 win_now(), out_len, out_err, e.win, e.len, e.err);
                    end
                end
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready got %b want %b (out_valid=%b out_ready=%b)",
                         in_ready, !out_valid || out_ready, out_valid, out_ready);
            end
            if (out_valid && !out_ready) begin
                if (prev_hold) begin
                    checks++;
                    if (win_now() !== prev_win || out_len !== prev_len || out_err !== prev_err) begin
                        errors++;
                        $display("FAIL hold_stable got win=%h len=%0d err=%0d want win=%h len=%0d err=%0d",
                                 win_now(), out_len, out_err, prev_win, prev_len, prev_err);
                    end
                end
                prev_hold = 1'b1;
                prev_win  = win_now();
                prev_len  = out_len;
                prev_err  = out_err;
            end else begin
                prev_hold = 1'b0;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Present one byte until accepted, then update the framing model.
    task automatic send_byte(input logic [7:0] b, output int waited);
        logic acc;
        exp_t e;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                errors++;
                $display("FAIL accept_timeout byte=%h not accepted after %0d cycles", b, waited);
                finish_run();
            end
        end
        in_valid = 1'b0;
        cur.push_back(b);
        if (!b[7] || cur.size() == 5) begin
            e.win = '0;
            foreach (cur[i]) e.win[i*8 +: 8] = cur[i];
            e.len = 3'(cur.size());
            e.err = b[7];
            sbq.push_back(e);
            cur.delete();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL latency out_valid got %b want 1 after terminating byte %h", out_valid, b);
            end
        end
    endtask

    task automatic send_list(input logic [7:0] bl [$]);
        int w;
        foreach (bl[i]) send_byte(bl[i], w);
    endtask

    task automatic drain();
        int n;
        rmode = 1;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
    endtask

    initial begin
        int w;
        logic [7:0] b;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; rmode = 2;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_len !== 3'd0 || win_now() !== 40'h0) begin
            errors++;
            $display("FAIL reset_state got valid=%b err=%b len=%0d win=%h want 0 0 0 0",
                     out_valid, out_err, out_len, win_now());
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end

        // Directed vectors with downstream always ready
        rmode = 1;
        send_list('{8'h7F});
        send_list('{8'hE5, 8'h8E, 8'h26});
        send_list('{8'h80, 8'h80, 8'h80, 8'h80, 8'h78});
        send_list('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        drain();

        // Backpressure: hold the window while a new byte waits
        rmode = 2;
        out_ready = 1'b0;
        send_byte(8'h05, w);
        in_valid = 1'b1;
        in_data  = 8'h06;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || o0 !== 8'h05 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall got in_ready=%b o0=%h valid=%b want 0 05 1", in_ready, o0, out_valid);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_byte(8'h06, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL same_cycle_accept got wait=%0d want 0", w);
        end
        drain();

        // Full-throughput single-byte stream
        for (int i = 1; i <= 3; i++) begin
            send_byte(8'(i), w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL stream_bubble byte=%0d got wait=%0d want 0", i, w);
            end
        end
        drain();

        // Asynchronous reset mid-varint
        send_list('{8'h80, 8'h81});
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || win_now() !== 40'h0 || out_len !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got valid=%b win=%h len=%0d want 0 0 0", out_valid, win_now(), out_len);
        end
        cur.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_list('{8'h01});
        drain();

        // Randomized stream with random gaps and random out_ready
        rmode = 0;
        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom);
            b[7] = ($urandom_range(0, 9) < 6);
            send_byte(b, w);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        if (cur.size() != 0) send_byte(8'h00, w);
        drain();

        finish_run();
    end

endmodule

`default_nettype wire

// File: doc/leb128_collect.md
Name: leb128_collect

Overview:
Upstream framing stage for the LEB128 decoders. It accepts a byte stream over a valid/ready handshake and gathers one complete LEB128 varint of at most 5 bytes. It presents the varint as a 5-byte parallel window (o0..o4) that drives the i0..i4 inputs of the combinational u32/i32 unpackers. It also reports byte count and an overlong-encoding error.

Parameters:
MAXB, 5, maximum bytes per varint (5 covers 32-bit values); window width is MAXB*8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  8  stream byte; bit7 = continuation (glue) bit
in_valid  input  1  in_data valid
in_ready  output  1  collector accepts in_data this cycle
o0..o4  output  8 each  collected bytes; o0 = first (least significant) byte
out_len  output  3  number of bytes collected, 1..MAXB
out_err  output  1  varint exceeded MAXB bytes (byte MAXB-1 had bit7 set)
out_valid  output  1  window holds a complete varint
out_ready  input  1  downstream consumes window

Behaviour:
- Reset: async on rst high. out_valid=0, out_err=0, out_len=0, o0..o4=0x00, byte index=0, state=COLLECT. in_ready=1 in the first cycle after rst deasserts.
- Byte acceptance occurs when in_valid & in_ready are both high at a rising clk edge.
- States:
  - COLLECT: in_ready=1, out_valid=0. An accepted byte is stored in slot[idx] and idx increments.
  - HOLD: out_valid=1. Window, out_len and out_err stay stable until out_ready.
- Termination in COLLECT:
  - Accepted byte with bit7=0 -> HOLD, out_len=idx+1, out_err=0.
  - Accepted byte at idx=MAXB-1 with bit7=1 -> HOLD, out_len=MAXB, out_err=1. The stored byte is kept unmodified. Following stream bytes are not skipped; resync is the upstream's responsibility.
  - Otherwise remain in COLLECT.
- Unused slots (index >= out_len) read as 0x00 in HOLD. The downstream unpackers derive used bytes from glue bits, so zero padding is required for the u32 result to be correct.
- Latency: out_valid rises on the clock edge that accepts the terminating byte, i.e. 1 cycle after that byte is presented with in_valid. Window contents are valid in the same cycle.
- HOLD exit:
  - On out_valid & out_ready, clear all slots to 0x00, set idx=0, clear out_len and out_err.
  - in_ready = (state==COLLECT) | (state==HOLD & out_ready). A byte accepted in the same cycle as the output handshake is stored in slot 0 of the next varint.
  - If that byte has bit7=0, the next state is HOLD again with out_len=1. This allows one single-byte varint per cycle at full throughput.
- While in HOLD with out_ready=0: in_ready=0, input stalled, outputs unchanged.
- in_valid=0 in COLLECT: no state change; a partial varint is retained indefinitely.
- Reset mid-varint discards partial bytes; the next accepted byte goes to slot 0.
- Any in_data value is legal; no X-propagation from unused slots (always 0x00).

Test Plan:
- Single byte 0x7F, out_ready=1 -> next cycle: out_valid=1, o0=0x7F, o1..o4=0x00, out_len=1, out_err=0 (i32 unpack gives 0xFFFFFFFF).
- Bytes 0xE5,0x8E,0x26 on consecutive cycles -> out_valid after 3rd byte: o0..o2=E5,8E,26, o3=o4=00, out_len=3, out_err=0 (u32 = 624485).
- Bytes 0x80,0x80,0x80,0x80,0x78 -> out_len=5, out_err=0 (i32 = 0x80000000). Then 0xFF x5 -> out_len=5, out_err=1, o4=0xFF.
- Backpressure: complete varint 0x05, hold out_ready=0 for 3 cycles with in_valid=1, in_data=0x06 -> in_ready=0, o0=0x05 stable. Raise out_ready -> 0x05 consumed and 0x06 accepted the same cycle; next cycle out_valid=1, o0=0x06, out_len=1.
- Streaming 0x01,0x02,0x03 with in_valid and out_ready held high -> out_valid high three consecutive cycles with o0=01,02,03, no bubbles.
- Assert rst after 0x80,0x81 accepted (idx=2) -> out_valid=0 immediately (async). After release, byte 0x01 -> o0=0x01, o1=0x00, out_len=1.
